// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: tracks in-flight destination tags per slot,
// picks forwarding sources and raises stall for not-yet-forwardable operands.
module hazard_scoreboard #(
  parameter int STAGES     = 3,
  parameter int READ_PORTS = 2,
  parameter int REG_AW     = 5,
  localparam int SEL_W     = $clog2(STAGES + 1),
  localparam int RDY_W     = $clog2(STAGES + 2)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic                         issue_wen,
  input  logic [REG_AW-1:0]            issue_dest,
  input  logic [RDY_W-1:0]             issue_rdy,
  input  logic                         issue_md,
  input  logic                         md_busy,
  input  logic [READ_PORTS-1:0]        rd_use,
  input  logic [READ_PORTS*REG_AW-1:0] rd_addr,
  input  logic                         flush_valid,
  input  logic [SEL_W-1:0]             flush_stage,
  output logic                         stall,
  output logic [READ_PORTS*SEL_W-1:0]  fwd_sel,
  output logic [31:0]                  stall_count
);

  localparam logic [RDY_W-1:0] RDY_MAX = RDY_W'(STAGES + 1);
  localparam logic [SEL_W-1:0] F_MAX   = SEL_W'(STAGES);

  // index i holds slot i+1 (slot 1 = E)
  logic [STAGES-1:0] v_q;
  logic [REG_AW-1:0] dest_q [STAGES];
  logic [RDY_W-1:0]  rdy_q  [STAGES];
  logic [31:0]       stall_count_q;

  logic              stall_dep;
  logic              load;
  logic [RDY_W-1:0]  rdy_clamp;
  logic [SEL_W-1:0]  f_eff;

  assign rdy_clamp = (issue_rdy > RDY_MAX) ? RDY_MAX : issue_rdy;
  assign f_eff     = (flush_stage > F_MAX) ? F_MAX : flush_stage;

  always_comb begin
    logic [REG_AW-1:0] addr;
    logic [RDY_W-1:0]  rdy_sel;
    int                sel;
    stall_dep = 1'b0;
    fwd_sel   = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      addr    = rd_addr[p*REG_AW +: REG_AW];
      sel     = 0;
      rdy_sel = '0;
      // walk oldest to youngest so the youngest match wins
      for (int s = STAGES; s >= 1; s--) begin
        if (rd_use[p] && addr != '0 && v_q[s-1] &&
            dest_q[s-1] == addr) begin
          sel     = s;
          rdy_sel = rdy_q[s-1];
        end
      end
      fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(sel);
      if (sel != 0 && sel < int'(rdy_sel))
        stall_dep = 1'b1;
    end
  end

  assign stall = issue_valid & (stall_dep | (issue_md & md_busy));
  assign load  = issue_valid & issue_wen & ~stall & ~flush_valid;
  assign stall_count = stall_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q           <= '0;
      stall_count_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        dest_q[i] <= '0;
        rdy_q[i]  <= '0;
      end
    end else begin
      v_q[0]    <= load;
      dest_q[0] <= issue_dest;
      rdy_q[0]  <= rdy_clamp;
      for (int i = 1; i < STAGES; i++) begin
        v_q[i]    <= v_q[i-1] & ~(flush_valid && i <= int'(f_eff));
        dest_q[i] <= dest_q[i-1];
        rdy_q[i]  <= rdy_q[i-1];
      end
      if (stall && stall_count_q != 32'hFFFF_FFFF)
        stall_count_q <= stall_count_q + 32'd1;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter STAGES, default 3, meaning the number of tag slots after issue (slot 1=E, 2=M, 3=W).
REQ-002 SHALL have parameter READ_PORTS, default 2, meaning the number of consumer register read ports checked at issue.
REQ-003 SHALL have parameter REG_AW, default 5, meaning the register address width.
REQ-004 SHALL derive SEL_W=clog2(STAGES+1) and RDY_W=clog2(STAGES+2).
REQ-005 SHALL have port clk  in  1  the single clock; one clock, all state rising-edge.
REQ-006 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have port issue_valid  in  1  instruction present in D.
REQ-008 SHALL have port issue_wen  in  1  the issuing instruction writes a register.
REQ-009 SHALL have port issue_dest  in  REG_AW  destination register.
REQ-010 SHALL have port issue_rdy  in  RDY_W  first slot index at which the result is forwardable.
REQ-011 SHALL have port issue_md  in  1  the issuing instruction uses the mul/div unit.
REQ-012 SHALL have port md_busy  in  1  the mul/div unit is busy.
REQ-013 SHALL have port rd_use  in  READ_PORTS  per-port read-valid.
REQ-014 SHALL have port rd_addr  in  READ_PORTS*REG_AW  per-port source register, port p at bits [p*REG_AW +: REG_AW].
REQ-015 SHALL have port flush_valid  in  1  flush request.
REQ-016 SHALL have port flush_stage  in  SEL_W  highest slot to kill (1..STAGES).
REQ-017 SHALL have port stall  out  1  hold F/D and inject a bubble.
REQ-018 SHALL have port fwd_sel  out  READ_PORTS*SEL_W  per-port forward source: 0=register file, s=slot s.
REQ-019 SHALL have port stall_count  out  32  saturating count of stall cycles.

Function
REQ-020 SHALL hold per slot a registered entry {valid, dest, rdy}; an entry is matchable only if valid and dest!=0.
REQ-021 SHALL load slot 1 at each edge with {1, issue_dest, min(issue_rdy, STAGES+1)} when issue_valid & issue_wen & ~stall & ~flush_valid, and otherwise with an invalid entry (bubble).
REQ-022 SHALL, for k=2..STAGES, set slot k <= slot k-1 every edge without back-pressure, except as modified by flush.
REQ-023 SHALL, when flush_valid=1 with f=flush_stage, invalidate slot 1 and every slot k with k-1<=f at the next edge; slots fed from above f advance normally, and the entry in slot STAGES retires.
REQ-024 SHALL treat flush_stage=0 as no kill beyond slot 1, and flush_stage>STAGES as STAGES.
REQ-025 SHALL, per port p with rd_use[p]=1 and rd_addr!=0, set fwd_sel[p] to the lowest (youngest) slot index s holding a matchable entry with dest==rd_addr, and to 0 if there is none or rd_use=0 or rd_addr=0.
REQ-026 SHALL assert stall combinationally when any port's selected slot s satisfies s < rdy of that entry.
REQ-027 SHALL also assert stall when issue_valid & issue_md & md_busy.
REQ-028 SHALL gate stall by issue_valid, so that stall=0 when issue_valid=0.
REQ-029 SHALL treat rdy=STAGES+1 as never forwardable: the consumer stalls until the entry retires, then fwd_sel=0.
REQ-030 SHALL keep fwd_sel valid during stall, reflecting the current youngest match.
REQ-031 SHALL increment stall_count at each edge where stall=1, and SHALL saturate it at 32'hFFFFFFFF with no wrap.
REQ-032 SHALL give flush priority over stall: issue is suppressed regardless, and stall is still reported.

Reset
REQ-033 SHALL, on rst=1, immediately and asynchronously invalidate all slots and clear stall_count to 0; stall=0 and fwd_sel=0 follow combinationally.
REQ-034 SHALL resume normal loading at the first rising edge after rst deasserts.

Verification
REQ-035 ALU-use: issue dest=5 rdy=2; next cycle port0 reads r5 -> stall=1, fwd_sel0=1 for one cycle; then stall=0, fwd_sel0=2.
REQ-036 Load-use: issue dest=8 rdy=3; next cycle port1 reads r8 -> stall=1 for two cycles (stall_count +2); then fwd_sel1=3, stall=0.
REQ-037 Youngest wins: slot1 dest=7 rdy=1 and slot2 dest=7 rdy=2 -> fwd_sel=1, stall=0; writes to r0 -> fwd_sel=0, stall=0.
REQ-038 Flush: slots 1..3 valid, flush_valid=1, flush_stage=2 -> after the edge all slots are invalid and a pending consumer sees fwd_sel=0, stall=0.
REQ-039 md_busy=1 with issue_md=1 -> stall=1 until md_busy falls; stall_count forced to 32'hFFFFFFFE plus 3 stall cycles -> holds at FFFFFFFF.
REQ-040 Reset mid-stall -> stall=0, stall_count=0, all fwd_sel=0 before the next edge.
